// File: rtl/vlsu_mem_responder.sv
// rtl/vlsu_mem_responder.sv - word-RAM responder for vlsu 1-4 beat read/write bursts
module vlsu_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned READ_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        wr_done,
    output logic        wr_err,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        rd_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    len_q, len_d;
    logic          err_q, err_d;
    logic [2:0]    beat_q, beat_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_last_q, rd_last_d;
    logic          rd_err_q, rd_err_d;
    logic          mem_we;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   req_widx;
    logic [32:0]   req_end;
    logic          req_legal;
    logic [AW-1:0] beat_idx;
    logic [2:0]    n_beats;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the bound check.
    assign req_widx  = (req_addr - BASE_ADDR) >> 2;
    assign req_end   = {1'b0, req_widx} + {30'b0, req_len};
    assign req_legal = (req_addr[1:0] == 2'b00) && (req_len != 3'd0) && (req_len <= 3'd4)
                       && (req_end <= 33'(DEPTH_WORDS));
    assign beat_idx  = idx_q + AW'(beat_q);
    // An illegal read still returns exactly one (error) beat.
    assign n_beats   = err_q ? 3'd1 : len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            beat_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_last_q  <= rd_last_d;
            rd_err_q   <= rd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        err_d      = err_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        rd_last_d  = rd_last_q;
        rd_err_d   = rd_err_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d  = req_widx[AW-1:0];
                    len_d  = req_len;
                    err_d  = !req_legal;
                    beat_d = '0;
                    cnt_d  = '0;
                    if (req_we) begin
                        state_d = (req_len == 3'd0) ? WR_RESP : WR_DATA;
                    end else begin
                        state_d = (READ_LAT <= 1) ? RD_DATA : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'(READ_LAT - 2)) begin
                    state_d = RD_DATA;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD_DATA: begin
                // Output register only advances when empty or being consumed, so stalls hold it.
                if (!rd_valid_q || rd_ready) begin
                    if (beat_q < n_beats) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = err_q ? 32'h0 : mem[beat_idx];
                        rd_last_d  = (beat_q == n_beats - 3'd1);
                        rd_err_d   = err_q;
                        beat_d     = beat_q + 3'd1;
                    end else begin
                        rd_valid_d = 1'b0;
                        rd_data_d  = '0;
                        rd_last_d  = 1'b0;
                        rd_err_d   = 1'b0;
                        beat_d     = '0;
                        state_d    = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (wr_valid) begin
                    mem_we = !err_q;
                    beat_d = beat_q + 3'd1;
                    if (beat_q == len_q - 3'd1) begin
                        beat_d  = '0;
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[beat_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR_DATA);
    assign wr_done   = (state_q == WR_RESP);
    assign wr_err    = (state_q == WR_RESP) && err_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;
    assign rd_err    = rd_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vlsu_mem_responder.sv
// tb/tb_vlsu_mem_responder.sv - self-checking bench for vlsu_mem_responder
module tb_vlsu_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_len;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_ready;
    logic [1:0]  sel;

    logic [2:0]  rv_v, req_ready_v, wr_ready_v, wr_done_v, wr_err_v;
    logic [2:0]  rd_valid_v, rd_last_v, rd_err_v, busy_v;
    logic [31:0] rd_data_v [3];

    logic        c_req_ready, c_wr_ready, c_wr_done, c_wr_err;
    logic        c_rd_valid, c_rd_last, c_rd_err, c_busy;
    logic [31:0] c_rd_data;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    bit          pat [$];

    always #5 clk = ~clk;

    assign rv_v        = req_valid ? 3'(3'b001 << sel) : 3'b000;
    assign c_req_ready = req_ready_v[sel];
    assign c_wr_ready  = wr_ready_v[sel];
    assign c_wr_done   = wr_done_v[sel];
    assign c_wr_err    = wr_err_v[sel];
    assign c_rd_valid  = rd_valid_v[sel];
    assign c_rd_last   = rd_last_v[sel];
    assign c_rd_err    = rd_err_v[sel];
    assign c_busy      = busy_v[sel];
    assign c_rd_data   = rd_data_v[sel];

    vlsu_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(rv_v[0]), .req_ready(req_ready_v[0]), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready_v[0]),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_done(wr_done_v[0]), .wr_err(wr_err_v[0]),
        .rd_valid(rd_valid_v[0]), .rd_ready(rd_ready), .rd_data(rd_data_v[0]),
        .rd_last(rd_last_v[0]), .rd_err(rd_err_v[0]), .busy(busy_v[0]));

    vlsu_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(rv_v[1]), .req_ready(req_ready_v[1]), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready_v[1]),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_done(wr_done_v[1]), .wr_err(wr_err_v[1]),
        .rd_valid(rd_valid_v[1]), .rd_ready(rd_ready), .rd_data(rd_data_v[1]),
        .rd_last(rd_last_v[1]), .rd_err(rd_err_v[1]), .busy(busy_v[1]));

    vlsu_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(8)) u_lat8 (
        .clk(clk), .rst(rst), .req_valid(rv_v[2]), .req_ready(req_ready_v[2]), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len), .wr_valid(wr_valid), .wr_ready(wr_ready_v[2]),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_done(wr_done_v[2]), .wr_err(wr_err_v[2]),
        .rd_valid(rd_valid_v[2]), .rd_ready(rd_ready), .rd_data(rd_data_v[2]),
        .rd_last(rd_last_v[2]), .rd_err(rd_err_v[2]), .busy(busy_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] addr, input int len);
        longint unsigned widx;
        widx = longint'(addr) >> 2;
        return (addr % 4 == 0) && len >= 1 && len <= 4 && widx + longint'(len) <= DEPTH;
    endfunction

    function automatic int exp_lat();
        return (sel == 2'd1) ? 1 : (sel == 2'd2) ? 8 : 2;
    endfunction

    // Ends on the falling edge after the accept edge, with req_valid dropped.
    task automatic do_req(input bit we, input logic [31:0] addr, input int len);
        int g;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_len = 3'(len);
        g = 0;
        while (!c_req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("req_ready", 32'(c_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input int len, input bit gaps);
        bit e_err;
        bit drove;
        int nb, g, base;
        e_err = !legal(addr, len);
        do_req(1'b1, addr, len);
        nb = 0; g = 0;
        while (nb < len && g < 100) begin
            g++;
            wr_valid = c_wr_ready && !(gaps && $urandom_range(0, 3) == 0);
            wr_data  = wd[nb];
            wr_strb  = ws[nb];
            drove    = wr_valid;
            @(posedge clk);
            if (drove) nb++;
            @(negedge clk);
            wr_valid = 1'b0;
        end
        chk("wr_beats", 32'(nb), 32'(len));
        chk("wr_done", 32'(c_wr_done), 32'd1);
        chk("wr_err", 32'(c_wr_err), 32'(e_err));
        @(negedge clk);
        chk("wr_done_pulse", 32'(c_wr_done), 32'd0);
        chk("wr_idle_ready", 32'(c_req_ready), 32'd1);
        if (!e_err) begin
            base = int'(addr >> 2);
            for (int k = 0; k < len; k++)
                for (int b = 0; b < 4; b++)
                    if (ws[k][b]) mdl[base + k][8*b +: 8] = wd[k][8*b +: 8];
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input bit rnd);
        logic [31:0] e_data [4];
        bit          e_err, held, rdy, full_rate;
        logic [31:0] hd;
        logic        hl;
        int n, lat, got, g;
        e_err = !legal(addr, len);
        n = e_err ? 1 : len;
        for (int k = 0; k < 4; k++)
            e_data[k] = (e_err || k >= n) ? 32'h0 : mdl[int'(addr >> 2) + k];
        full_rate = !rnd && pat.size() == 0;
        do_req(1'b0, addr, len);
        lat = 0;
        while (!c_rd_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("rd_latency", 32'(lat), 32'(exp_lat()));
        got = 0; g = 0; held = 1'b0; hd = '0; hl = 1'b0;
        while (got < n && g < 100) begin
            g++;
            if (held) chk("rd_valid_held", 32'(c_rd_valid), 32'd1);
            if (c_rd_valid) begin
                if (held) begin
                    chk("rd_stable_data", c_rd_data, hd);
                    chk("rd_stable_last", 32'(c_rd_last), 32'(hl));
                end
                if (pat.size() > 0) rdy = pat.pop_front();
                else rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                rd_ready = rdy;
                if (rdy) begin
                    chk("rd_data", c_rd_data, e_data[got]);
                    chk("rd_last", 32'(c_rd_last), 32'(got == n - 1));
                    chk("rd_err", 32'(c_rd_err), 32'(e_err));
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = c_rd_data;
                    hl = c_rd_last;
                end
            end else begin
                rd_ready = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("rd_beats", 32'(got), 32'(n));
        if (full_rate) chk("rd_rate", 32'(g), 32'(n));
        chk("rd_valid_after", 32'(c_rd_valid), 32'd0);
        chk("busy_after", 32'(c_busy), 32'd0);
        chk("req_ready_after", 32'(c_req_ready), 32'd1);
    endtask

    initial begin
        int word, len;
        logic [31:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0; sel = 2'd0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(c_req_ready), 32'd1);
        chk("rst_busy", 32'(c_busy), 32'd0);
        chk("rst_rd_valid", 32'(c_rd_valid), 32'd0);
        chk("rst_wr_ready", 32'(c_wr_ready), 32'd0);
        chk("rst_wr_done", 32'(c_wr_done), 32'd0);
        chk("rst_rd_data", c_rd_data, 32'd0);
        rst = 1'b0;

        // Fill words 0..15 so every read in the window has a known value.
        for (int w = 0; w < 16; w += 4) begin
            for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
            do_write(32'(w * 4), 4, 1'b0);
        end

        // T1
        for (int k = 0; k < 4; k++) begin wd[k] = 32'h1111_1111 * 32'(k + 1); ws[k] = 4'hF; end
        do_write(32'h10, 4, 1'b0);
        do_read(32'h10, 4, 1'b0);
        chk("t1_model_w7", mdl[7], 32'h4444_4444);

        // T2
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(32'h0, 1, 1'b0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
        do_write(32'h0, 1, 1'b0);
        do_read(32'h0, 1, 1'b0);
        chk("t2_model_w0", mdl[0], 32'hFFBB_FFDD);

        // T3
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_read(32'h20, 4, 1'b0);

        // T4
        do_read(32'h12, 1, 1'b0);
        wd[0] = 32'h5A5A_0001; ws[0] = 4'hF;
        do_write(32'((DEPTH - 1) * 4), 1, 1'b0);
        wd[0] = 32'hDEAD_BEEF; wd[1] = 32'hCAFE_F00D; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'((DEPTH - 1) * 4), 2, 1'b0);
        do_read(32'((DEPTH - 1) * 4), 1, 1'b0);
        do_write(32'h20, 0, 1'b0);
        do_read(32'h20, 0, 1'b0);

        // T5
        do_req(1'b0, 32'h10, 4);
        len = 0;
        while (!c_rd_valid && len < 20) begin @(posedge clk); len++; @(negedge clk); end
        rd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_beat", c_rd_data, mdl[4 + k]);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1; rd_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rd_valid", 32'(c_rd_valid), 32'd0);
        chk("t5_req_ready", 32'(c_req_ready), 32'd1);
        chk("t5_busy", 32'(c_busy), 32'd0);
        rst = 1'b0;
        do_read(32'h10, 4, 1'b0);

        // T6
        for (int s = 1; s <= 2; s++) begin
            sel = 2'(s);
            for (int k = 0; k < 4; k++) begin wd[k] = mdl[k]; ws[k] = 4'hF; end
            do_write(32'h0, 4, 1'b0);
            do_read(32'h0, 4, 1'b0);
            do_read(32'h3, 2, 1'b0);
        end
        sel = 2'd0;

        // Randomized bursts against the model.
        for (int it = 0; it < 60; it++) begin
            len  = $urandom_range(0, 4);
            word = $urandom_range(0, 15);
            if (word + len > 16) word = 16 - len;
            addr = 32'(word * 4);
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
                do_write(addr, len, 1'b1);
            end else begin
                do_read(addr, len, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
